sysbus_decoder: RTL and testbench
=================================

// Module: sysbus_decoder
// PURPOSE
// - Parametrised system-bus address decoder and read-return mux between the RISC_V core bus and NUM_SLAVES targets (data memory, gemm config, ...).
// - Decodes the top DEC_BITS of the address, forwards the request to exactly one slave and word-aligns the address.
// - Tracks in-flight reads in a RD_LAT-deep pipeline and returns the data of the slave that was addressed.
// - Adds an optional output register, unmapped-address error response and a sticky error capture register.
// PARAMETERS
// - NUM_SLAVES   2          number of targets (1..8)
// - DEC_BITS     4          address MSBs compared against region tags
// - REGION_TAGS  {4'h9,4'h0} NUM_SLAVES*DEC_BITS packed tags; slave i tag = [i*DEC_BITS +: DEC_BITS]
// - HAS_DEFAULT  1          1: unmatched address goes to DEFAULT_SLAVE; 0: unmatched = error
// - DEFAULT_SLAVE 0         index of the default slave
// - RD_LAT       1          fixed slave read latency in cycles (1..4)
// - OUT_REG      0          1: register m_rd_data/m_rd_valid (+1 cycle)
// - ERR_DATA     32'hDEAD_BEEF  read data returned for an unmapped read
// PORTS
// - clk            in   1        clock
// - rst            in   1        synchronous active-high reset
// - m_en           in   1        core bus request strobe (one access per cycle, no stall)
// - m_rdwr         in   1        1 = write, 0 = read
// - m_addr         in   32       byte address
// - m_wr_data      in   32       write data
// - m_mask         in   4        byte-enable mask
// - m_rd_data      out  32       read data returned to core
// - m_rd_valid     out  1        m_rd_data valid for a completed read
// - s_en           out  NUM_SLAVES  one-hot slave enable
// - s_rdwr         out  1        m_rdwr broadcast
// - s_addr         out  32       {m_addr[31:2],2'b00} broadcast
// - s_wr_data      out  32       m_wr_data broadcast
// - s_mask         out  4        m_mask broadcast
// - s_rd_data      in   NUM_SLAVES*32  slave read data; slave i = [i*32 +: 32]
// - err_flag       out  1        sticky: an unmapped access occurred
// - err_addr       out  32       byte address of the first unmapped access since the last clear
// - err_clr        in   1        clears err_flag/err_addr
// BEHAVIOUR
// - Decode (combinational): hit[i] = m_addr[31 -: DEC_BITS] == tag i. On multiple hits the lowest index wins.
//   No hit: DEFAULT_SLAVE if HAS_DEFAULT, otherwise unmapped.
// - s_en[sel] = m_en and mapped; all other s_en bits are 0. Unmapped accesses drive no s_en.
// - Broadcast signals (s_rdwr/s_addr/s_wr_data/s_mask) are combinational pass-through and are driven even when s_en = 0.
// - Read tracking: each cycle, push {valid = m_en & ~m_rdwr, sel, unmapped} into a RD_LAT-stage shift register.
//   Writes push valid = 0.
// - Return: at the stage-RD_LAT output with valid = 1:
//   - mapped: m_rd_data = s_rd_data[sel]
//   - unmapped: m_rd_data = ERR_DATA
//   - m_rd_valid = 1
//   - Otherwise m_rd_valid = 0 and m_rd_data holds its previous value.
// - Latency: a read issued in cycle T returns in cycle T+RD_LAT (OUT_REG = 0) or T+RD_LAT+1 (OUT_REG = 1).
// - Back-to-back reads to different slaves return in order, one per cycle, with no bubbles.
// - Errors: an unmapped access (read or write) with err_flag = 0 sets err_flag = 1 and err_addr = m_addr on the next edge.
//   - Later errors do not overwrite err_addr while err_flag = 1.
//   - err_clr alone clears both registers to 0.
//   - err_clr together with a new error: the new error wins (flag = 1, addr = new address).
//   - Unmapped writes have no other effect.
// - Reset: tracking pipeline valid bits = 0, m_rd_valid = 0, m_rd_data = 0, err_flag = 0, err_addr = 0.
//   - Reads in flight at reset never produce m_rd_valid.
//   - Requests presented in the reset cycle are ignored; s_en is forced to 0 while rst = 1.
// - Assertions: s_en is one-hot-or-zero; m_rd_valid is never asserted for a write.
// TESTING
// - Default params: read 0x0000_0010, slave0 returns 0x1111_1111 -> s_en = 2'b01, s_addr = 0x10; next cycle m_rd_valid = 1, m_rd_data = 0x1111_1111.
// - Read 0x9000_0007 -> s_en = 2'b10, s_addr = 0x9000_0004; gemm data 0xCAFE_0001 returned at T+1.
//   A read to 0x0 issued at T+1 returns memory data at T+2 with no bubble.
// - RD_LAT = 3, OUT_REG = 1: reads at T, T+1 to slaves 1, 0 -> m_rd_valid at T+4 and T+5 carrying slave1 then slave0 data, in order.
// - HAS_DEFAULT = 0: write to 0x5000_0000 -> s_en = 0, err_flag = 1, err_addr = 0x5000_0000.
//   A following read of 0x6000_0000 -> m_rd_data = 0xDEAD_BEEF; err_addr unchanged.
// - err_clr in the same cycle as an unmapped access to 0x7000_0004 -> err_flag = 1, err_addr = 0x7000_0004.
//   err_clr alone -> err_flag = 0, err_addr = 0.
// - Read at T with rst = 1 at T+1 (RD_LAT = 2) -> m_rd_valid stays 0 through T+4.

Source files
------------

// File: rtl/sysbus_decoder.sv
// System-bus address decoder: routes each core access to one slave by address MSBs and
// returns read data from the addressed slave after a fixed latency, with error capture.
module sysbus_decoder #(
  parameter int                             NUM_SLAVES    = 2,
  parameter int                             DEC_BITS      = 4,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] REGION_TAGS   = {4'h9, 4'h0},
  parameter bit                             HAS_DEFAULT   = 1'b1,
  parameter int                             DEFAULT_SLAVE = 0,
  parameter int                             RD_LAT        = 1,
  parameter bit                             OUT_REG       = 1'b0,
  parameter logic [31:0]                    ERR_DATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_en,
  input  logic                     m_rdwr,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wr_data,
  input  logic [3:0]               m_mask,
  output logic [31:0]              m_rd_data,
  output logic                     m_rd_valid,
  output logic [NUM_SLAVES-1:0]    s_en,
  output logic                     s_rdwr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wr_data,
  output logic [3:0]               s_mask,
  input  logic [NUM_SLAVES*32-1:0] s_rd_data,
  output logic                     err_flag,
  output logic [31:0]              err_addr,
  input  logic                     err_clr
);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [NUM_SLAVES-1:0] hit;
  logic [SW-1:0]         sel;
  logic                  mapped;
  logic [31:0]           s_word [NUM_SLAVES];

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
    assign hit[i]    = (m_addr[31 -: DEC_BITS] == REGION_TAGS[i*DEC_BITS +: DEC_BITS]);
    assign s_word[i] = s_rd_data[i*32 +: 32];
  end

  // Walk downwards so the lowest matching index is the one left standing.
  always_comb begin
    sel    = SW'(DEFAULT_SLAVE);
    mapped = HAS_DEFAULT;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel    = SW'(i);
        mapped = 1'b1;
      end
    end
  end

  always_comb begin
    s_en = '0;
    if (m_en && mapped && !rst) s_en[sel] = 1'b1;
  end

  assign s_rdwr    = m_rdwr;
  assign s_addr    = {m_addr[31:2], 2'b00};
  assign s_wr_data = m_wr_data;
  assign s_mask    = m_mask;

  // Read tracking: stage s holds the access issued s cycles ago.
  logic [RD_LAT:1]         vld_pipe;
  logic [RD_LAT:1]         wr_pipe;
  logic [RD_LAT:1]         unm_pipe;
  logic [RD_LAT:1][SW-1:0] sel_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      wr_pipe  <= '0;
    end else begin
      vld_pipe[1] <= m_en & ~m_rdwr;
      wr_pipe[1]  <= m_en & m_rdwr;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        wr_pipe[s]  <= wr_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    unm_pipe[1] <= ~mapped;
    sel_pipe[1] <= sel;
    for (int s = 2; s <= RD_LAT; s++) begin
      unm_pipe[s] <= unm_pipe[s-1];
      sel_pipe[s] <= sel_pipe[s-1];
    end
  end

  logic        ret_vld;
  logic [31:0] ret_data;
  logic [31:0] data_q;
  logic        vld_q;

  assign ret_vld  = vld_pipe[RD_LAT];
  assign ret_data = unm_pipe[RD_LAT] ? ERR_DATA : s_word[sel_pipe[RD_LAT]];

  // data_q doubles as the output register and as the hold value between returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= ret_vld;
      if (ret_vld) data_q <= ret_data;
    end
  end

  assign m_rd_valid = (OUT_REG ? vld_q : ret_vld) & ~rst;
  assign m_rd_data  = (!OUT_REG && ret_vld) ? ret_data : data_q;

  logic new_err;
  assign new_err = m_en & ~mapped;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (new_err && (!err_flag || err_clr)) begin
      err_flag <= 1'b1;
      err_addr <= m_addr;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end
  end

  a_onehot: assert property (@(posedge clk) $onehot0(s_en));
  a_no_wr_ret: assert property (@(posedge clk) disable iff (rst) !(vld_pipe[RD_LAT] && wr_pipe[RD_LAT]));

endmodule

// File: tb/tb_sysbus_decoder.sv
// Bench for sysbus_decoder: three configurations share one request stream; a scoreboard
// per instance predicts each read return cycle and data.
module tb_sysbus_decoder;
  localparam int N = 3;
  localparam int LAT  [N] = '{1, 3, 2};
  localparam bit OREG [N] = '{1'b0, 1'b1, 1'b0};
  localparam bit HDEF [N] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_en = 1'b0, m_rdwr = 1'b0, err_clr = 1'b0;
  logic [31:0] m_addr = '0, m_wr_data = '0;
  logic [3:0]  m_mask = '0;
  logic [63:0] s_rd;
  int          cyc = 0;

  logic [31:0] rdata [N];
  logic        rvld  [N];
  logic [1:0]  sen   [N];
  logic        srdwr [N];
  logic [31:0] saddr [N];
  logic [31:0] swd   [N];
  logic [3:0]  smask [N];
  logic        eflag [N];
  logic [31:0] eaddr [N];

  int checks = 0;
  int errors = 0;

  typedef struct { int samp; int due; int sel; bit unm; } ret_t;
  ret_t        sbq [N][$];
  logic [31:0] last [N] = '{default: '0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sdat(int i, int c);
    logic [31:0] cc;
    cc = c;
    return ((i == 0) ? 32'h1111_0000 : 32'hCAFE_0000) | {16'h0, cc[15:0]};
  endfunction

  assign s_rd = {sdat(1, cyc), sdat(0, cyc)};

  for (genvar g = 0; g < N; g++) begin : g_dut
    sysbus_decoder #(.HAS_DEFAULT(HDEF[g]), .RD_LAT(LAT[g]), .OUT_REG(OREG[g])) u_dut (
      .clk(clk), .rst(rst), .m_en(m_en), .m_rdwr(m_rdwr), .m_addr(m_addr),
      .m_wr_data(m_wr_data), .m_mask(m_mask), .m_rd_data(rdata[g]), .m_rd_valid(rvld[g]),
      .s_en(sen[g]), .s_rdwr(srdwr[g]), .s_addr(saddr[g]), .s_wr_data(swd[g]),
      .s_mask(smask[g]), .s_rd_data(s_rd), .err_flag(eflag[g]), .err_addr(eaddr[g]),
      .err_clr(err_clr)
    );
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference decode: tag 0 -> slave 0, tag 9 -> slave 1, anything else default or unmapped.
  task automatic dec(logic [31:0] a, bit hdef, output int sel, output bit unm);
    sel = 0;
    unm = 1'b0;
    if (a[31:28] == 4'h9) sel = 1;
    else if (a[31:28] != 4'h0) unm = !hdef;
  endtask

  task automatic drive(bit en, bit wr, logic [31:0] a, logic [31:0] wd, logic [3:0] mk,
                       bit clr, bit r);
    ret_t e;
    @(posedge clk);
    #1;
    rst = r; m_en = en; m_rdwr = wr; m_addr = a; m_wr_data = wd; m_mask = mk; err_clr = clr;
    if (en && !wr && !r) begin
      for (int k = 0; k < N; k++) begin
        dec(a, HDEF[k], e.sel, e.unm);
        e.samp = cyc + LAT[k];
        e.due  = e.samp + (OREG[k] ? 1 : 0);
        sbq[k].push_back(e);
      end
    end
  endtask

  task automatic idle(bit r = 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, r);
  endtask

  task automatic mon(int k);
    ret_t        e;
    logic [31:0] exp;
    if (rst) begin
      chk($sformatf("rst_vld[%0d]", k), 32'(rvld[k]), 32'h0);
      sbq[k].delete();
      last[k] = '0;
      return;
    end
    if (sbq[k].size() > 0 && sbq[k][0].due < cyc) begin
      e = sbq[k].pop_front();
      chk($sformatf("missing_ret[%0d] due %0d", k, e.due), 32'h0, 32'h1);
    end
    if (rvld[k]) begin
      if (sbq[k].size() == 0) begin
        chk($sformatf("spurious_ret[%0d]", k), 32'(rvld[k]), 32'h0);
      end else begin
        e   = sbq[k].pop_front();
        exp = e.unm ? 32'hDEAD_BEEF : sdat(e.sel, e.samp);
        chk($sformatf("ret_cycle[%0d]", k), 32'(cyc), 32'(e.due));
        chk($sformatf("ret_data[%0d]", k), rdata[k], exp);
        last[k] = exp;
      end
    end else begin
      chk($sformatf("hold_data[%0d]", k), rdata[k], last[k]);
    end
  endtask

  always @(negedge clk) for (int k = 0; k < N; k++) mon(k);

  typedef struct {
    bit en; bit wr; logic [31:0] addr; logic [31:0] wd; logic [3:0] mk;
    logic [1:0] en_ab; logic [1:0] en_c; logic [31:0] sa;
  } vec_t;
  vec_t tv [10];

  initial begin
    int t0;
    tv[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 2'b01, 2'b01, 32'h0000_0010};
    tv[1] = '{1'b1, 1'b0, 32'h9000_0007, 32'h0,         4'hF, 2'b10, 2'b10, 32'h9000_0004};
    tv[2] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h3, 2'b01, 2'b01, 32'h0000_0000};
    tv[3] = '{1'b1, 1'b1, 32'h9000_1000, 32'h1234_5678, 4'h5, 2'b10, 2'b10, 32'h9000_1000};
    tv[4] = '{1'b1, 1'b0, 32'h5000_0000, 32'h0,         4'hF, 2'b01, 2'b00, 32'h5000_0000};
    tv[5] = '{1'b1, 1'b0, 32'hF000_0003, 32'h0,         4'hF, 2'b01, 2'b00, 32'hF000_0000};
    tv[6] = '{1'b1, 1'b1, 32'h0FFF_FFFF, 32'hA5A5_A5A5, 4'h8, 2'b01, 2'b01, 32'h0FFF_FFFC};
    tv[7] = '{1'b1, 1'b0, 32'h8FFF_FFFC, 32'h0,         4'hF, 2'b01, 2'b00, 32'h8FFF_FFFC};
    tv[8] = '{1'b1, 1'b0, 32'h9FFF_FFFF, 32'h0,         4'hF, 2'b10, 2'b10, 32'h9FFF_FFFC};
    tv[9] = '{1'b0, 1'b0, 32'h9000_0000, 32'h0,         4'h0, 2'b00, 2'b00, 32'h9000_0000};

    idle(1'b1);
    drive(1'b1, 1'b0, 32'h9000_0010, 32'h0, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < N; k++) chk($sformatf("sen_in_rst[%0d]", k), 32'(sen[k]), 32'h0);
    idle(1'b0);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset_vld[%0d]", k),   32'(rvld[k]),  32'h0);
      chk($sformatf("reset_data[%0d]", k),  rdata[k],      32'h0);
      chk($sformatf("reset_eflag[%0d]", k), 32'(eflag[k]), 32'h0);
      chk($sformatf("reset_eaddr[%0d]", k), eaddr[k],      32'h0);
    end

    // Back-to-back decode vectors; read returns are verified by the scoreboard.
    for (int v = 0; v < 10; v++) begin
      drive(tv[v].en, tv[v].wr, tv[v].addr, tv[v].wd, tv[v].mk, 1'b0, 1'b0);
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        chk($sformatf("v%0d s_en[%0d]", v, k), 32'(sen[k]), 32'((k == 2) ? tv[v].en_c : tv[v].en_ab));
        chk($sformatf("v%0d s_addr[%0d]", v, k), saddr[k], tv[v].sa);
        chk($sformatf("v%0d s_wr_data[%0d]", v, k), swd[k], tv[v].wd);
        chk($sformatf("v%0d s_mask[%0d]", v, k), 32'(smask[k]), 32'(tv[v].mk));
        chk($sformatf("v%0d s_rdwr[%0d]", v, k), 32'(srdwr[k]), 32'(tv[v].wr));
      end
    end
    chk("err_flag_after_tbl", 32'(eflag[2]), 32'h1);
    chk("err_addr_first_kept", eaddr[2], 32'h5000_0000);
    chk("err_flag_default_a", 32'(eflag[0]), 32'h0);

    // Error capture sequences on the no-default instance.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    idle(); @(negedge clk);
    chk("clr_flag", 32'(eflag[2]), 32'h0);
    chk("clr_addr", eaddr[2], 32'h0);
    drive(1'b1, 1'b1, 32'h5000_0000, 32'h0, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h6000_0000, 32'h0, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    chk("unm_wr_sen", 32'(sen[2]), 32'h0);
    chk("unm_wr_flag", 32'(eflag[2]), 32'h1);
    chk("unm_wr_addr", eaddr[2], 32'h5000_0000);
    idle(); @(negedge clk);
    chk("second_err_addr_kept", eaddr[2], 32'h5000_0000);
    drive(1'b1, 1'b1, 32'h7000_0004, 32'h0, 4'hF, 1'b1, 1'b0);
    idle(); @(negedge clk);
    chk("clr_new_err_flag", 32'(eflag[2]), 32'h1);
    chk("clr_new_err_addr", eaddr[2], 32'h7000_0004);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    idle(); @(negedge clk);
    chk("clr2_flag", 32'(eflag[2]), 32'h0);
    chk("clr2_addr", eaddr[2], 32'h0);

    // Long-latency registered instance: slave1 then slave0 back to back.
    drive(1'b1, 1'b0, 32'h9000_0000, 32'h0, 4'hF, 1'b0, 1'b0);
    t0 = cyc;
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle(); @(negedge clk);
      if (cyc == t0 + 4) begin
        chk("b_ret1_vld", 32'(rvld[1]), 32'h1);
        chk("b_ret1_data", rdata[1], sdat(1, t0 + 3));
      end else if (cyc == t0 + 5) begin
        chk("b_ret2_vld", 32'(rvld[1]), 32'h1);
        chk("b_ret2_data", rdata[1], sdat(0, t0 + 4));
      end
    end

    // Read in flight when reset arrives must never return.
    drive(1'b1, 1'b0, 32'h9000_0000, 32'h0, 4'hF, 1'b0, 1'b0);
    idle(1'b1); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      idle(); @(negedge clk);
      for (int k = 0; k < N; k++) chk($sformatf("post_rst_vld[%0d]", k), 32'(rvld[k]), 32'h0);
    end

    for (int i = 0; i < 8; i++) idle();
    @(negedge clk);
    for (int k = 0; k < N; k++) chk($sformatf("drain[%0d]", k), 32'(sbq[k].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
